// File: rtl/uart_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler: drain FSM state
// encoding, the UART status bit that reports a frame in flight, requester
// IDs and a small width helper used for counter sizing.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam int STATUS_TX_BUSY_BIT = 1;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Bits needed to count 0..value-1, never less than one so that degenerate
  // parameter values still give a legal vector.
  function automatic int min_width(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/uart_sched_fifo.sv
// -----------------------------------------------------------------------------
// uart_sched_fifo
// Synchronous first-word-fall-through FIFO shared by both byte requesters.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   push, push_data       write one entry (ignored when full)
//   pop                   drop the head entry (ignored when empty)
//   pop_data              current head entry
//   full, empty, count    occupancy status
// -----------------------------------------------------------------------------
module uart_sched_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: resetting the pointers already discards it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between the CPU console (port 0) and the
// debug/trace logger (port 1). A round-robin arbiter loads a shared FIFO; a
// drain FSM writes each byte to the UART data register, waits for the TX busy
// flag to rise and fall, retries writes the UART never acknowledged and drops
// a byte after MAX_RETRY retries.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   i_valid0/i_data0/o_ready0  console requester handshake
//   i_valid1/i_data1/o_ready1  debug logger requester handshake
//   i_uart_status              UART status register (bit 1 = TX busy)
//   o_RW, o_uart_data_ce,      write cycle to the UART data register
//   o_uart_txdata              (o_RW = 0 means write)
//   o_fifo_count               shared FIFO occupancy
//   o_drop                     one-cycle pulse when a byte is abandoned
// Optional (macro UART_SCHED_STATS_EN):
//   o_sent0, o_sent1           completed frames per source, wrapping
//   o_drops                    abandoned bytes, saturating at 0xFF
// -----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid0,
  input  logic [7:0]  i_data0,
  output logic        o_ready0,
  input  logic        i_valid1,
  input  logic [7:0]  i_data1,
  output logic        o_ready1,
  input  logic [7:0]  i_uart_status,
  output logic        o_RW,
  output logic        o_uart_data_ce,
  output logic [7:0]  o_uart_txdata,
  output logic [6:0]  o_fifo_count,
  output logic        o_drop
`ifdef UART_SCHED_STATS_EN
  ,
  output logic [15:0] o_sent0,
  output logic [15:0] o_sent1,
  output logic [7:0]  o_drops
`endif
);

  localparam int TW  = min_width(BUSY_TIMEOUT);
  localparam int RTW = min_width(MAX_RETRY + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_SCHED_STATS_EN
  localparam int FW  = 9;
`else
  localparam int FW  = 8;
`endif

  sched_state_t   state;
  sched_state_t   next_state;
  logic           last_grant;
  logic           grant0;
  logic           grant1;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [FW-1:0]  fifo_wr;
  logic [FW-1:0]  fifo_rd;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     hold_data;
  logic [RTW-1:0] retry_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           tmo_expired;
  logic           retry_inc;
  logic           retry_clr;
  logic           frame_done;
  logic           tx_busy;
  logic [7:0]     unused_status;

  assign tx_busy       = i_uart_status[STATUS_TX_BUSY_BIT];
  assign unused_status = i_uart_status & ~(8'd1 << STATUS_TX_BUSY_BIT);
  assign tmo_expired   = (tmo_cnt == TW'(BUSY_TIMEOUT - 1));
  assign o_fifo_count  = 7'(fifo_count);
  assign o_ready0      = grant0;
  assign o_ready1      = grant1;

  // Round-robin grant. A lone requester always wins; when both ask, the one
  // not served last time wins. Nothing is granted while full or in reset so
  // requesters simply hold their byte.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !fifo_full) begin
      if (i_valid0 && i_valid1) begin
        if (last_grant == REQ_CPU) grant1 = 1'b1;
        else                       grant0 = 1'b1;
      end else begin
        grant0 = i_valid0;
        grant1 = i_valid1;
      end
    end
  end

  // Pointer starts as if the debug port was served last so the console wins
  // the first contested cycle; it only moves on an actual grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= REQ_DBG;
    else if (grant0) last_grant <= REQ_CPU;
    else if (grant1) last_grant <= REQ_DBG;
  end

`ifdef UART_SCHED_STATS_EN
  assign fifo_wr = grant1 ? {REQ_DBG, i_data1} : {REQ_CPU, i_data0};
`else
  assign fifo_wr = grant1 ? i_data1 : i_data0;
`endif

  uart_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant0 || grant1),
    .push_data (fifo_wr),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and bus outputs. The bus is only driven during WRITE; every
  // other state leaves it released (read direction, chip enable low).
  always_comb begin
    next_state     = state;
    fifo_pop       = 1'b0;
    o_drop         = 1'b0;
    o_RW           = 1'b1;
    o_uart_data_ce = 1'b0;
    o_uart_txdata  = 8'h00;
    retry_inc      = 1'b0;
    retry_clr      = 1'b0;
    frame_done     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        o_RW           = 1'b0;
        o_uart_data_ce = 1'b1;
        o_uart_txdata  = hold_data;
        next_state     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if (tmo_expired) begin
          if (retry_cnt < RTW'(MAX_RETRY)) begin
            retry_inc  = 1'b1;
            next_state = WRITE;
          end else begin
            o_drop     = 1'b1;
            retry_clr  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
          retry_clr  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Holding register, retry count and busy timeout. The timeout restarts on
  // each write and saturates rather than wrapping if it is ever left running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= 8'h00;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (fifo_pop) hold_data <= fifo_rd[7:0];
      if (state == WRITE)
        tmo_cnt <= '0;
      else if (state == WAIT_BUSY && tmo_cnt != {TW{1'b1}})
        tmo_cnt <= tmo_cnt + TW'(1);
      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RTW'(1);
    end
  end

`ifdef UART_SCHED_STATS_EN
  logic hold_src;

  // Per-source completion counters wrap; the drop counter sticks at 0xFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_src <= REQ_CPU;
      o_sent0  <= 16'h0000;
      o_sent1  <= 16'h0000;
      o_drops  <= 8'h00;
    end else begin
      if (fifo_pop) hold_src <= fifo_rd[8];
      if (frame_done) begin
        if (hold_src == REQ_CPU) o_sent0 <= o_sent0 + 16'd1;
        else                     o_sent1 <= o_sent1 + 16'd1;
      end
      if (o_drop && o_drops != 8'hFF) o_drops <= o_drops + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int FIFO_DEPTH   = 16;
  localparam int BUSY_TIMEOUT = 8;
  localparam int MAX_RETRY    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       ready0;
  logic       valid1 = 1'b0;
  logic [7:0] data1 = 8'h00;
  logic       ready1;
  logic [7:0] uart_status;
  logic       rw;
  logic       data_ce;
  logic [7:0] txdata;
  logic [6:0] fifo_count;
  logic       drop;
`ifdef UART_SCHED_STATS_EN
  logic [15:0] sent0;
  logic [15:0] sent1;
  logic [7:0]  drops;
`endif

  // UART model: busy rises 2 clocks after a write and holds busy_len clocks.
  logic busy_model = 1'b0;
  logic force_busy = 1'b0;
  logic respond = 1'b1;
  int   busy_len = 3;
  int   busy_delay = 0;
  int   busy_hold = 0;

  int   assert_count = 0;
  int   fail_count = 0;
  int   writes_seen = 0;
  int   drops_seen = 0;
  int   w0, d0, n;
  logic [7:0] exp_byte;
  logic [7:0] sb[$];

  assign uart_status = {6'b0, busy_model | force_busy, 1'b0};

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_valid0       (valid0),
    .i_data0        (data0),
    .o_ready0       (ready0),
    .i_valid1       (valid1),
    .i_data1        (data1),
    .o_ready1       (ready1),
    .i_uart_status  (uart_status),
    .o_RW           (rw),
    .o_uart_data_ce (data_ce),
    .o_uart_txdata  (txdata),
    .o_fifo_count   (fifo_count),
    .o_drop         (drop)
`ifdef UART_SCHED_STATS_EN
    ,
    .o_sent0        (sent0),
    .o_sent1        (sent1),
    .o_drops        (drops)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Bus monitor, scoreboard and UART busy model, all on the falling edge.
  always @(negedge clk) begin
    logic wr;
    wr = data_ce && !rw;
    if (wr) begin
      writes_seen++;
      checkOutput("write_while_busy", 32'(uart_status[1]), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 32'(sb.size()), 32'd1);
      end else begin
        exp_byte = sb.pop_front();
        checkOutput("write_data", 32'(txdata), 32'(exp_byte));
      end
    end
    if (drop) drops_seen++;
    if (busy_model) begin
      busy_hold--;
      if (busy_hold <= 0) busy_model = 1'b0;
    end
    if (busy_delay > 0) begin
      busy_delay--;
      if (busy_delay == 0) begin
        busy_model = 1'b1;
        busy_hold  = busy_len;
      end
    end
    if (wr && respond) busy_delay = 2;
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    force_busy = 1'b0;
    respond = 1'b1;
    busy_model = 1'b0;
    busy_delay = 0;
    busy_hold = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Offer one byte on a port, wait (bounded) for its grant and record how
  // many write cycles it is expected to produce.
  task automatic applyStimulus(input int port, input logic [7:0] data, input int writes);
    int waited;
    waited = 0;
    @(negedge clk);
    if (port == 0) begin valid0 = 1'b1; data0 = data; end
    else           begin valid1 = 1'b1; data1 = data; end
    #1;
    while (((port == 0) ? !ready0 : !ready1) && waited < 500) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("grant_seen", 32'((port == 0) ? ready0 : ready1), 32'd1);
    for (int i = 0; i < writes; i++) sb.push_back(data);
    @(posedge clk);
    #1;
    if (port == 0) valid0 = 1'b0;
    else           valid1 = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    int cnt;
    logic done;
    cnt = 0;
    done = 1'b0;
    while (!done && cnt < max_cycles) begin
      @(negedge clk);
      #1;
      cnt++;
      done = (sb.size() == 0) && !busy_model && (busy_delay == 0) && (fifo_count == 7'd0);
    end
    checkOutput("drain_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state, with both requesters asking so a grant would be visible.
    valid0 = 1'b1; data0 = 8'h5A;
    valid1 = 1'b1; data1 = 8'hA5;
    #1;
    checkOutput("rst_rw", 32'(rw), 32'd1);
    checkOutput("rst_ce", 32'(data_ce), 32'd0);
    checkOutput("rst_txdata", 32'(txdata), 32'd0);
    checkOutput("rst_ready0", 32'(ready0), 32'd0);
    checkOutput("rst_ready1", 32'(ready1), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);

    // Single console byte with a long frame.
    $display("[TB] single byte on port 0");
    doReset();
    busy_len = 100;
    w0 = writes_seen;
    applyStimulus(0, 8'h41, 1);
    waitDrain(400);
    checkOutput("single_write_count", 32'(writes_seen - w0), 32'd1);
    checkOutput("single_count", 32'(fifo_count), 32'd0);
    checkOutput("single_rw_idle", 32'(rw), 32'd1);
    checkOutput("single_ce_idle", 32'(data_ce), 32'd0);

    // Both ports contending continuously: grants alternate from port 0.
    $display("[TB] round-robin contention");
    doReset();
    busy_len = 3;
    @(negedge clk);
    valid0 = 1'b1; data0 = 8'hAA;
    valid1 = 1'b1; data1 = 8'h55;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("rr_ready0", 32'(ready0), 32'((i % 2) == 0));
      checkOutput("rr_ready1", 32'(ready1), 32'((i % 2) == 1));
      sb.push_back(((i % 2) == 0) ? 8'hAA : 8'h55);
      @(negedge clk);
    end
    valid0 = 1'b0;
    valid1 = 1'b0;
    waitDrain(500);

    // Fill the FIFO while the UART stays busy.
    $display("[TB] FIFO full with busy held");
    doReset();
    busy_len = 3;
    applyStimulus(0, 8'h01, 1);
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); #1; n++; end
    checkOutput("first_write_seen", 32'(sb.size()), 32'd0);
    @(negedge clk);
    force_busy = 1'b1;
    @(negedge clk);
    valid0 = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      data0 = 8'(8'h10 + i);
      #1;
      checkOutput("fill_ready0", 32'(ready0), 32'd1);
      sb.push_back(data0);
      @(negedge clk);
    end
    data0 = 8'h20;
    valid1 = 1'b1; data1 = 8'hEE;
    #1;
    checkOutput("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_ready0", 32'(ready0), 32'd0);
      checkOutput("full_ready1", 32'(ready1), 32'd0);
      @(negedge clk);
      #1;
    end
    valid1 = 1'b0;
    force_busy = 1'b0;
    @(negedge clk); #1;
    checkOutput("release_ready0", 32'(ready0), 32'd0);
    @(negedge clk); #1;
    checkOutput("after_pop_ready0", 32'(ready0), 32'd1);
    checkOutput("after_pop_count", 32'(fifo_count), 32'(FIFO_DEPTH - 1));
    sb.push_back(8'h20);
    @(posedge clk); #1;
    valid0 = 1'b0;
    waitDrain(2000);

    // UART never acknowledges: initial write plus retries, then one drop.
    $display("[TB] busy timeout and drop");
    doReset();
    busy_len = 3;
    respond = 1'b0;
    w0 = writes_seen;
    d0 = drops_seen;
    applyStimulus(0, 8'hE7, MAX_RETRY + 1);
    applyStimulus(0, 8'h3C, 1);
    n = 0;
    while (drops_seen == d0 && n < 200) begin @(negedge clk); #1; n++; end
    respond = 1'b1;
    checkOutput("drop_seen", 32'(drops_seen - d0), 32'd1);
    waitDrain(300);
    checkOutput("drop_single_pulse", 32'(drops_seen - d0), 32'd1);
    checkOutput("retry_write_count", 32'(writes_seen - w0), 32'(MAX_RETRY + 2));

    // Reset while a frame is in flight and five bytes are queued.
    $display("[TB] reset during frame");
    doReset();
    busy_len = 100;
    applyStimulus(0, 8'hA0, 1);
    for (int k = 1; k <= 5; k++) applyStimulus(0, 8'(8'hA0 + k), 0);
    n = 0;
    while (!busy_model && n < 50) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk);
    #1;
    checkOutput("queued_count", 32'(fifo_count), 32'd5);
    @(negedge clk);
    valid0 = 1'b1; data0 = 8'h77;
    reset = 1'b1;
    #1;
    checkOutput("midrst_rw", 32'(rw), 32'd1);
    checkOutput("midrst_ce", 32'(data_ce), 32'd0);
    checkOutput("midrst_txdata", 32'(txdata), 32'd0);
    checkOutput("midrst_ready0", 32'(ready0), 32'd0);
    checkOutput("midrst_count", 32'(fifo_count), 32'd0);
    checkOutput("midrst_drop", 32'(drop), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    valid0 = 1'b0;
    w0 = writes_seen;
    repeat (150) @(negedge clk);
    checkOutput("no_write_after_reset", 32'(writes_seen - w0), 32'd0);
    busy_len = 3;
    applyStimulus(0, 8'h99, 1);
    waitDrain(300);
    checkOutput("post_reset_write", 32'(writes_seen - w0), 32'd1);

`ifdef UART_SCHED_STATS_EN
    $display("[TB] statistics counters");
    doReset();
    busy_len = 3;
    applyStimulus(0, 8'hC1, 1);
    applyStimulus(0, 8'hC2, 1);
    applyStimulus(0, 8'hC3, 1);
    applyStimulus(1, 8'hD1, 1);
    applyStimulus(1, 8'hD2, 1);
    waitDrain(500);
    checkOutput("stats_sent0", 32'(sent0), 32'd3);
    checkOutput("stats_sent1", 32'(sent1), 32'd2);
    checkOutput("stats_drops", 32'(drops), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between two on-chip byte sources: port 0, the 6809 console path, and port 1, the hardware debug/trace logger. A round-robin arbiter accepts bytes into a shared FIFO. A drain FSM then issues write cycles to the UART data register and tracks the UART busy flag (status bit 1) until each frame completes. The block sits between the requesters and uart_interface, driving its i_RW / i_uart_data_ce / i_uart_rxdata inputs.

Parameters:
FIFO_DEPTH, 16, shared FIFO entries; power of two, 2..64.
BUSY_TIMEOUT, 1024, clk cycles to wait for busy to assert after a write before retrying.
MAX_RETRY, 3, retries of one byte before it is dropped.

Ports:
clk  input  1  system clock (the UART block's clock)
reset  input  1  asynchronous, active-high reset
i_valid0  input  1  requester 0 (CPU console) has a byte
i_data0  input  8  requester 0 byte
o_ready0  output  1  requester 0 byte accepted this cycle
i_valid1  input  1  requester 1 (debug logger) has a byte
i_data1  input  8  requester 1 byte
o_ready1  output  1  requester 1 byte accepted this cycle
i_uart_status  input  8  UART status register; bit 1 = TX busy
o_RW  output  1  bus direction to UART; 0 = write
o_uart_data_ce  output  1  UART data register chip enable
o_uart_txdata  output  8  byte presented to UART data register
o_fifo_count  output  7  current FIFO occupancy
o_drop  output  1  one-cycle pulse when a byte is dropped after MAX_RETRY

Behaviour:
- Reset values: o_RW=1, o_uart_data_ce=0, o_uart_txdata=0, o_ready0/1=0, o_fifo_count=0, o_drop=0. FIFO is emptied, round-robin pointer set to favour port 0, FSM in IDLE, retry and timeout counters cleared.
- Arbiter: at most one byte accepted per clk, and only when the FIFO is not full.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the port not granted last time is granted; the pointer moves only on a grant.
  - o_readyN is a registered-free combinational grant. Data is written into the FIFO on the same edge.
- FIFO full: both ready signals stay 0; requesters hold their valid and data.
- Simultaneous push and pop on the same edge: count is unchanged. Push into an empty FIFO becomes visible to the FSM on the next cycle.
- Drain FSM states:
  - IDLE: if FIFO not empty, pop the head into the holding register and go to WRITE.
  - WRITE: one cycle with o_RW=0, o_uart_data_ce=1, o_uart_txdata = holding byte. Clear the timeout counter and go to WAIT_BUSY.
  - WAIT_BUSY: if status[1]=1, go to WAIT_DONE. Otherwise, when the timeout counter reaches BUSY_TIMEOUT-1:
    - if retry < MAX_RETRY, increment retry and go to WRITE;
    - else pulse o_drop, clear retry and go to IDLE.
  - WAIT_DONE: when status[1]=0, clear retry and go to IDLE.
- Latency: a byte at the FIFO head reaches the UART bus 2 clks after IDLE sees non-empty.
- Back-to-back frames: a new write is never issued while status[1]=1.
- o_RW returns to 1 and o_uart_data_ce to 0 in every state other than WRITE.
- Timeout counter width is clog2(BUSY_TIMEOUT). The counter saturates and never wraps.
- Reset asserted mid-frame: the holding byte and FIFO contents are discarded and the bus is released immediately (asynchronous).

Optional Feature:
UART_SCHED_STATS_EN:
- Defined: adds outputs o_sent0 and o_sent1 (16 bits each), counting bytes per source that completed WAIT_DONE; they wrap at 0xFFFF. Adds o_drops (8 bits), counting drops and saturating at 0xFF. The FIFO carries a source-ID bit per entry.
- Not defined: none of these ports or counters exist, and the FIFO is 8 bits wide.

Decomposition:
- Package uart_sched_pkg:
  - FSM state encoding: IDLE=2'd0, WRITE=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3;
  - STATUS_TX_BUSY_BIT=1;
  - requester ID constants REQ_CPU=0, REQ_DBG=1.
- Sub-module uart_sched_fifo: synchronous FIFO parameterised by depth and width, with push, pop, full, empty and count.
- Arbiter and FSM stay in the top module.

Test Plan:
- Only port 0 sends 0x41; the UART model raises busy 2 clks after the write and holds it 100 clks. Expect exactly one write cycle with data 0x41; IDLE is re-entered after busy falls; fifo_count returns to 0.
- Both ports valid continuously with 0xAA and 0x55. Expect grants to alternate 0,1,0,1, and UART writes in the order AA,55,AA,55.
- Fill to 16 with busy held at 1. Expect o_ready0/1=0 while full and count=16; after busy drops, the next grant appears the cycle after the first pop.
- The UART model never asserts busy, with BUSY_TIMEOUT=8 and MAX_RETRY=3. Expect 4 write cycles for the same byte, then a single o_drop pulse, then the next byte is written.
- Assert reset during WAIT_DONE with 5 bytes queued. Expect the outputs to take their reset values immediately and no further writes after release until new requests arrive.
- With UART_SCHED_STATS_EN defined: send 3 bytes on port 0 and 2 on port 1. Expect o_sent0=3, o_sent1=2, o_drops=0.
